wb_host_master: RTL and testbench

Wishbone master stage that sits directly upstream of the generated register banks. It accepts single-word read/write commands from a local host port and drives them as one pipelined Wishbone cycle each into the slave's `wb_*` inputs. It returns read data, completion and a status code to the host, and bounds every cycle with a timeout and a retry limit.

---
 rtl/wb_host_master.sv | 174 +++++++++++++++++
 tb/tb_wb_host_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master
// Brief    : Single-word host command to pipelined Wishbone cycle, with
//            timeout and retry limits, returning status and read data.
// Revision : 1.0
// ============================================================================
module wb_host_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int RETRIES    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_adr_i,
    input  logic [3:0]            host_sel_i,
    input  logic [31:0]           host_dat_i,
    output logic                  host_busy_o,
    output logic                  host_done_o,
    output logic [1:0]            host_status_o,
    output logic [31:0]           host_dat_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_WAIT    = 2'd2;
    localparam logic [1:0] c_BACKOFF = 2'd3;

    localparam logic [1:0] c_ST_OK  = 2'b00;
    localparam logic [1:0] c_ST_ERR = 2'b01;
    localparam logic [1:0] c_ST_TMO = 2'b10;
    localparam logic [1:0] c_ST_RTY = 2'b11;

    // Counter holds the number of cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  c_RTY_MAX  = 4'(RETRIES);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [1:0]            w_status;
    logic [15:0]           r_tmo;
    logic [3:0]            r_rty;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_wdat;
    logic                  r_done;
    logic [1:0]            r_status;
    logic [31:0]           r_rdat;
    logic                  w_active;
    logic                  w_timeout;
    logic                  w_rty_ok;
    logic                  w_cmd_done;
    logic                  w_rd_ok;
    logic                  w_cyc;
    logic                  w_stb;
    logic                  w_busy;

    assign w_active   = (r_state == c_REQ) || (r_state == c_WAIT);
    assign w_timeout  = (r_tmo == c_TMO_LAST);
    assign w_rty_ok   = (r_rty < c_RTY_MAX);
    assign w_cmd_done = (r_state != c_IDLE) && (w_next == c_IDLE);
    assign w_rd_ok    = w_active && wb_ack_i && !wb_err_i && !wb_rty_i && !r_we;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Responses outrank both the timeout and the stall decision.
    always_comb begin
        w_next   = r_state;
        w_status = c_ST_OK;
        case (r_state)
            c_IDLE: begin
                if (host_req_i) w_next = c_REQ;
            end
            c_REQ, c_WAIT: begin
                if (wb_err_i) begin
                    w_next   = c_IDLE;
                    w_status = c_ST_ERR;
                end else if (wb_rty_i) begin
                    if (w_rty_ok) begin
                        w_next = c_BACKOFF;
                    end else begin
                        w_next   = c_IDLE;
                        w_status = c_ST_RTY;
                    end
                end else if (wb_ack_i) begin
                    w_next = c_IDLE;
                end else if (w_timeout) begin
                    w_next   = c_IDLE;
                    w_status = c_ST_TMO;
                end else if ((r_state == c_REQ) && !wb_stall_i) begin
                    w_next = c_WAIT;
                end
            end
            default: begin
                if (w_timeout) begin
                    w_next   = c_IDLE;
                    w_status = c_ST_TMO;
                end else begin
                    w_next = c_REQ;
                end
            end
        endcase
    end

    always_comb begin
        w_cyc  = w_active;
        w_stb  = (r_state == c_REQ);
        w_busy = (r_state != c_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo    <= '0;
            r_rty    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_wdat   <= '0;
            r_done   <= 1'b0;
            r_status <= c_ST_OK;
            r_rdat   <= '0;
        end else begin
            r_done <= w_cmd_done;
            if (w_cmd_done) r_status <= w_status;
            if (w_rd_ok)    r_rdat   <= wb_dat_i;
            if (r_state == c_IDLE) begin
                if (host_req_i) begin
                    r_we   <= host_we_i;
                    r_adr  <= host_adr_i;
                    r_sel  <= host_sel_i;
                    r_wdat <= host_dat_i;
                    r_tmo  <= '0;
                    r_rty  <= '0;
                end
            end else begin
                if (r_tmo != c_TMO_LAST) r_tmo <= r_tmo + 16'd1;
                if (w_active && !wb_err_i && wb_rty_i && w_rty_ok) r_rty <= r_rty + 4'd1;
            end
        end
    end

    assign host_busy_o   = w_busy;
    assign host_done_o   = r_done;
    assign host_status_o = r_status;
    assign host_dat_o    = r_rdat;
    assign wb_cyc_o      = w_cyc;
    assign wb_stb_o      = w_stb;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_sel_o      = r_sel;
    assign wb_dat_o      = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_host_master
// Brief    : Directed vector bench for wb_host_master with a small bank model.
// Revision : 1.0
// ============================================================================
module tb_wb_host_master;

    localparam int c_F_ACK    = 0;
    localparam int c_F_ERR    = 1;
    localparam int c_F_ERRACK = 2;
    localparam int c_F_NONE   = 3;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          stall;   // stall cycles before the strobe is taken
        int          delay;   // WAIT cycles before the response; <0 = answer in REQ
        int          nrty;    // rty answers before the final response
        int          fin;
        bit          poke;    // pulse host_req while busy
        logic [1:0]  e_st;
        logic [31:0] e_dat;
        int          e_stb;
        int          e_cyc;
        int          e_gap;
        int          e_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [3:0]  host_adr = '0, host_sel = '0;
    logic [31:0] host_dat = '0;
    logic        host_busy_o, host_done_o;
    logic [1:0]  host_status_o;
    logic [31:0] host_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_adr_o, wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;
    logic [31:0] wb_dat = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    string       tag;
    logic [31:0] mem [16];
    vec_t        vecs [11];

    always #5 clk = ~clk;

    wb_host_master #(.ADDR_WIDTH(4), .TIMEOUT(8), .RETRIES(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .host_req_i(host_req), .host_we_i(host_we), .host_adr_i(host_adr),
        .host_sel_i(host_sel), .host_dat_i(host_dat),
        .host_busy_o(host_busy_o), .host_done_o(host_done_o),
        .host_status_o(host_status_o), .host_dat_o(host_dat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
        .wb_stall_i(wb_stall), .wb_dat_i(wb_dat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Called on a negedge; plays host and slave for one command.
    task automatic run_cmd(input vec_t v);
        int stall_left, wcnt, rty_sent, cyc_n, stb_n, gap_n, lat, extra;
        bit accepted, responded, fire;
        stall_left = v.stall; wcnt = 0; rty_sent = 0;
        cyc_n = 0; stb_n = 0; gap_n = 0; lat = 0; extra = 0;
        accepted = 0; responded = 0;
        host_req = 1'b1; host_we = v.we; host_adr = v.adr; host_sel = v.sel; host_dat = v.dat;
        @(negedge clk);
        host_req = 1'b0; host_we = ~v.we; host_adr = ~v.adr; host_sel = ~v.sel; host_dat = ~v.dat;
        for (int c = 1; c <= 60; c++) begin
            wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
            wb_dat = $urandom();
            if (host_done_o) begin
                lat = c;
                break;
            end
            if (c == 1) check("busy at issue", 32'(host_busy_o), 32'd1);
            host_req = v.poke && (c == 2);
            if (wb_cyc_o) cyc_n++; else gap_n++;
            if (wb_stb_o && stb_n == 0) begin
                check("wb_we", 32'(wb_we_o), 32'(v.we));
                check("wb_adr", 32'(wb_adr_o), 32'(v.adr));
                check("wb_sel", 32'(wb_sel_o), 32'(v.sel));
                check("wb_dat", wb_dat_o, v.dat);
            end
            fire = 0;
            if (wb_cyc_o && !responded) begin
                if (wb_stb_o) begin
                    stb_n++;
                    wb_stall = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                    if (v.delay < 0) fire = 1;
                    else if (!wb_stall) begin accepted = 1; wcnt = v.delay; end
                end else if (accepted) begin
                    if (wcnt == 0) fire = 1; else wcnt--;
                end
            end else if (wb_stb_o) begin
                stb_n++;
            end
            if (fire) begin
                if (rty_sent < v.nrty) begin
                    wb_rty = 1'b1; rty_sent++; accepted = 0;
                end else begin
                    responded = 1;
                    case (v.fin)
                        c_F_ACK: begin
                            wb_ack = 1'b1;
                            if (wb_we_o) begin
                                for (int b = 0; b < 4; b++)
                                    if (wb_sel_o[b]) mem[wb_adr_o][8*b +: 8] = wb_dat_o[8*b +: 8];
                            end else begin
                                wb_dat = mem[wb_adr_o];
                            end
                        end
                        c_F_ERR:    wb_err = 1'b1;
                        c_F_ERRACK: begin wb_err = 1'b1; wb_ack = 1'b1; end
                        default:    responded = 0;
                    endcase
                end
            end
            @(negedge clk);
        end
        host_req = 1'b0;
        check("done seen", 32'(lat != 0), 32'd1);
        check("latency", 32'(lat), 32'(v.e_lat));
        check("status", 32'(host_status_o), 32'(v.e_st));
        check("rdata", host_dat_o, v.e_dat);
        check("stb cycles", 32'(stb_n), 32'(v.e_stb));
        check("cyc cycles", 32'(cyc_n), 32'(v.e_cyc));
        check("backoff gaps", 32'(gap_n), 32'(v.e_gap));
        check("busy at done", 32'(host_busy_o), 32'd0);
        @(negedge clk);
        check("done one cycle", 32'(host_done_o), 32'd0);
        repeat (3) begin
            if (wb_cyc_o || host_done_o) extra++;
            @(negedge clk);
        end
        check("idle after done", 32'(extra), 32'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        vecs[0]  = '{1'b1, 4'd0, 4'hF, 32'hDEADBEEF, 0,  2, 0, c_F_ACK,    1'b0, 2'd0, 32'h0,        1, 4, 0, 5};
        vecs[1]  = '{1'b0, 4'd0, 4'hF, 32'h0,        0,  1, 0, c_F_ACK,    1'b0, 2'd0, 32'hDEADBEEF, 1, 3, 0, 4};
        vecs[2]  = '{1'b0, 4'd0, 4'hF, 32'h0,        5,  1, 0, c_F_ACK,    1'b0, 2'd0, 32'hDEADBEEF, 6, 8, 0, 9};
        vecs[3]  = '{1'b0, 4'd1, 4'hF, 32'h0,        0,  0, 0, c_F_NONE,   1'b1, 2'd2, 32'hDEADBEEF, 1, 8, 0, 9};
        vecs[4]  = '{1'b0, 4'd0, 4'hF, 32'h0,        0, -1, 3, c_F_ACK,    1'b0, 2'd0, 32'hDEADBEEF, 4, 4, 3, 8};
        vecs[5]  = '{1'b0, 4'd0, 4'hF, 32'h0,        0, -1, 4, c_F_ACK,    1'b0, 2'd3, 32'hDEADBEEF, 4, 4, 3, 8};
        vecs[6]  = '{1'b1, 4'd2, 4'hF, 32'h55,       0,  0, 0, c_F_ERRACK, 1'b0, 2'd1, 32'hDEADBEEF, 1, 2, 0, 3};
        vecs[7]  = '{1'b1, 4'd3, 4'h5, 32'h12345678, 0,  2, 0, c_F_ACK,    1'b0, 2'd0, 32'hDEADBEEF, 1, 4, 0, 5};
        vecs[8]  = '{1'b0, 4'd3, 4'hF, 32'h0,        0,  1, 0, c_F_ACK,    1'b0, 2'd0, 32'h00340078, 1, 3, 0, 4};
        vecs[9]  = '{1'b0, 4'd2, 4'hF, 32'h0,        2, -1, 0, c_F_ACK,    1'b0, 2'd0, 32'h0,        1, 1, 0, 2};
        vecs[10] = '{1'b0, 4'd0, 4'hF, 32'h0,        0,  1, 0, c_F_ACK,    1'b0, 2'd0, 32'hDEADBEEF, 1, 3, 0, 4};

        tag = "reset";
        repeat (2) @(negedge clk);
        check("cyc", 32'(wb_cyc_o), 32'd0);
        check("stb", 32'(wb_stb_o), 32'd0);
        check("we/adr/sel", {27'd0, wb_we_o, wb_adr_o}, 32'd0);
        check("wb_dat/sel", wb_dat_o | 32'(wb_sel_o), 32'd0);
        check("busy/done", {30'd0, host_busy_o, host_done_o}, 32'd0);
        check("status", 32'(host_status_o), 32'd0);
        check("rdata", host_dat_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("vec%0d", i);
            run_cmd(vecs[i]);
        end

        // Request held across done: ignored in REQ, accepted in the done cycle.
        tag = "b2b";
        host_req = 1'b1; host_we = 1'b0; host_adr = 4'd5;
        @(negedge clk);
        check("busy", 32'(host_busy_o), 32'd1);
        wb_ack = 1'b1; wb_dat = 32'hCAFE0001; host_adr = 4'd6;
        @(negedge clk);
        check("done1", 32'(host_done_o), 32'd1);
        check("data1", host_dat_o, 32'hCAFE0001);
        check("cyc low at done", 32'(wb_cyc_o), 32'd0);
        wb_ack = 1'b0;
        @(negedge clk);
        check("reissue cyc", 32'(wb_cyc_o), 32'd1);
        check("reissue adr", 32'(wb_adr_o), 32'd6);
        host_req = 1'b0; wb_ack = 1'b1; wb_dat = 32'hCAFE0002;
        @(negedge clk);
        check("done2", 32'(host_done_o), 32'd1);
        check("data2", host_dat_o, 32'hCAFE0002);
        wb_ack = 1'b0;
        @(negedge clk);

        // Reset while in WAIT.
        tag = "midreset";
        host_req = 1'b1; host_we = 1'b0; host_adr = 4'd0;
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);
        check("in wait", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("cyc async", 32'(wb_cyc_o), 32'd0);
        check("stb async", 32'(wb_stb_o), 32'd0);
        check("busy", 32'(host_busy_o), 32'd0);
        check("rdata", host_dat_o, 32'd0);
        check("adr/status", {26'd0, wb_adr_o, host_status_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (host_done_o || wb_cyc_o) seen++;
        end
        check("no done after reset", 32'(seen), 32'd0);
        tag = "vec10";
        run_cmd(vecs[10]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
